// File: rtl/rf_write_arbiter.sv
// Register file write-port arbiter. In-order pipeline writebacks take priority
// over results from the multi-cycle unit. Those results wait in a small FIFO
// and are written when the write port is free. A per-register pending vector
// and a starvation stall request go to the hazard unit.
module rf_write_arbiter #(
  parameter int unsigned N      = 5,
  parameter int unsigned M      = 32,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned STARVE = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    wb_we,
  input  logic [N-1:0]            wb_a3,
  input  logic [M-1:0]            wb_wd,
  input  logic                    mc_valid,
  input  logic [N-1:0]            mc_a3,
  input  logic [M-1:0]            mc_wd,
  output logic                    mc_ready,
  output logic                    rf_we,
  output logic [N-1:0]            rf_a3,
  output logic [M-1:0]            rf_wd,
  output logic [2**N-1:0]         pending,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    stall_req
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned AW = $clog2(STARVE + 1);
  localparam logic [CW-1:0] DepthC  = CW'(DEPTH);
  localparam logic [AW-1:0] StarveC = AW'(STARVE);

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [AW-1:0] age_q, age_d;
  logic          rf_we_q, rf_we_d;
  logic [N-1:0]  rf_a3_q, rf_a3_d;
  logic [M-1:0]  rf_wd_q, rf_wd_d;
  logic [N-1:0]  mem_a3_q [DEPTH];
  logic [N-1:0]  mem_a3_d [DEPTH];
  logic [M-1:0]  mem_wd_q [DEPTH];
  logic [M-1:0]  mem_wd_d [DEPTH];

  logic wb_grant, accept, push, pop, fifo_empty;

  // Handshake and grant decisions; mc_ready depends only on registered occupancy.
  always_comb begin
    fifo_empty = (count_q == '0);
    mc_ready   = (count_q < DepthC);
    wb_grant   = wb_we && (wb_a3 != '0);
    accept     = mc_valid && mc_ready;
    // Writes to x0 complete the handshake but are never queued.
    push       = accept && (mc_a3 != '0);
    pop        = !wb_grant && !fifo_empty;
  end

  // Next-state: FIFO pointers/storage, occupancy, starvation age, write port.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    age_d    = age_q;
    rf_we_d  = 1'b0;
    rf_a3_d  = rf_a3_q;
    rf_wd_d  = rf_wd_q;
    mem_a3_d = mem_a3_q;
    mem_wd_d = mem_wd_q;

    if (push) begin
      mem_a3_d[wr_ptr_q] = mc_a3;
      mem_wd_d[wr_ptr_q] = mc_wd;
      wr_ptr_d           = wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end

    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    if (fifo_empty || pop) begin
      age_d = '0;
    end else if (age_q != StarveC) begin
      age_d = age_q + AW'(1);
    end

    if (wb_grant) begin
      rf_we_d = 1'b1;
      rf_a3_d = wb_a3;
      rf_wd_d = wb_wd;
    end else if (pop) begin
      rf_we_d = 1'b1;
      rf_a3_d = mem_a3_q[rd_ptr_q];
      rf_wd_d = mem_wd_q[rd_ptr_q];
    end
  end

  // Control state with synchronous reset; a reset drops every queued entry.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      age_q    <= '0;
      rf_we_q  <= 1'b0;
      rf_a3_q  <= '0;
      rf_wd_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      age_q    <= age_d;
      rf_we_q  <= rf_we_d;
      rf_a3_q  <= rf_a3_d;
      rf_wd_q  <= rf_wd_d;
    end
  end

  // FIFO storage; contents are qualified by occupancy so need no reset.
  always_ff @(posedge clk) begin
    mem_a3_q <= mem_a3_d;
    mem_wd_q <= mem_wd_d;
  end

  // Pending vector: one-hot destination of every occupied slot, ORed together.
  always_comb begin
    logic [PW-1:0] slot_off;
    slot_off = '0;
    pending  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      slot_off = PW'(i) - rd_ptr_q;
      if ({1'b0, slot_off} < count_q) begin
        pending[mem_a3_q[i]] = 1'b1;
      end
    end
  end

  assign rf_we     = rf_we_q;
  assign rf_a3     = rf_a3_q;
  assign rf_wd     = rf_wd_q;
  assign count     = count_q;
  assign stall_req = (age_q == StarveC);

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed bench for rf_write_arbiter: inputs change and outputs are sampled
// 1 ns after each rising edge.
module tb_rf_write_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        wb_we;
  logic [4:0]  wb_a3;
  logic [31:0] wb_wd;
  logic        mc_valid;
  logic [4:0]  mc_a3;
  logic [31:0] mc_wd;
  logic        mc_ready;
  logic        rf_we;
  logic [4:0]  rf_a3;
  logic [31:0] rf_wd;
  logic [31:0] pending;
  logic [2:0]  count;
  logic        stall_req;

  int checks = 0;
  int errors = 0;

  rf_write_arbiter #(.N(5), .M(32), .DEPTH(4), .STARVE(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .wb_we     (wb_we),
    .wb_a3     (wb_a3),
    .wb_wd     (wb_wd),
    .mc_valid  (mc_valid),
    .mc_a3     (mc_a3),
    .mc_wd     (mc_wd),
    .mc_ready  (mc_ready),
    .rf_we     (rf_we),
    .rf_a3     (rf_a3),
    .rf_wd     (rf_wd),
    .pending   (pending),
    .count     (count),
    .stall_req (stall_req)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] bit_of(input int r);
    logic [31:0] one;
    one = 32'd1;
    return one << r;
  endfunction

  initial begin
    reset = 1'b1; wb_we = 1'b0; wb_a3 = '0; wb_wd = '0;
    mc_valid = 1'b0; mc_a3 = '0; mc_wd = '0;
    tick(); tick();
    chk("rst_rf_we", rf_we, 1'b0);
    chk("rst_rf_a3", rf_a3, 5'd0);
    chk("rst_rf_wd", rf_wd, 32'd0);
    chk("rst_count", count, 3'd0);
    chk("rst_pending", pending, 32'd0);
    chk("rst_mc_ready", mc_ready, 1'b1);
    chk("rst_stall", stall_req, 1'b0);
    reset = 1'b0;

    // mc only: 2-cycle latency, pending bit visible exactly one cycle.
    mc_valid = 1'b1; mc_a3 = 5'd5; mc_wd = 32'hDEADBEEF;
    tick();
    mc_valid = 1'b0;
    chk("mc_pending_set", pending, bit_of(5));
    chk("mc_count1", count, 3'd1);
    chk("mc_no_write_yet", rf_we, 1'b0);
    tick();
    chk("mc_rf_we", rf_we, 1'b1);
    chk("mc_rf_a3", rf_a3, 5'd5);
    chk("mc_rf_wd", rf_wd, 32'hDEADBEEF);
    chk("mc_pending_clr", pending, 32'd0);
    chk("mc_count0", count, 3'd0);
    tick();
    chk("idle_rf_we", rf_we, 1'b0);
    chk("idle_rf_a3_hold", rf_a3, 5'd5);

    // Priority: wb wins while two mc entries wait, then they drain in order.
    wb_we = 1'b1; wb_a3 = 5'd3; wb_wd = 32'h11;
    mc_valid = 1'b1; mc_a3 = 5'd7; mc_wd = 32'h70;
    tick();
    chk("pri_wb0_a3", rf_a3, 5'd3);
    chk("pri_wb0_we", rf_we, 1'b1);
    chk("pri_count1", count, 3'd1);
    mc_a3 = 5'd9; mc_wd = 32'h90;
    tick();
    mc_valid = 1'b0;
    chk("pri_wb1_a3", rf_a3, 5'd3);
    chk("pri_count2", count, 3'd2);
    chk("pri_pending", pending, bit_of(7) | bit_of(9));
    tick();
    chk("pri_wb2_a3", rf_a3, 5'd3);
    chk("pri_wb2_wd", rf_wd, 32'h11);
    wb_we = 1'b0;
    tick();
    chk("pri_mc7_a3", rf_a3, 5'd7);
    chk("pri_mc7_wd", rf_wd, 32'h70);
    chk("pri_pending9", pending, bit_of(9));
    chk("pri_count_after7", count, 3'd1);
    tick();
    chk("pri_mc9_a3", rf_a3, 5'd9);
    chk("pri_mc9_wd", rf_wd, 32'h90);
    chk("pri_count_empty", count, 3'd0);
    tick();
    chk("pri_idle_we", rf_we, 1'b0);

    // Full: four accepts with wb busy, a fifth held until after the first pop.
    wb_we = 1'b1; wb_a3 = 5'd4; wb_wd = 32'h44;
    for (int i = 0; i < 4; i++) begin
      mc_valid = 1'b1; mc_a3 = 5'(10 + i); mc_wd = 32'hA0 + 32'(i);
      tick();
    end
    chk("full_wb_a3", rf_a3, 5'd4);
    chk("full_count", count, 3'd4);
    chk("full_not_ready", mc_ready, 1'b0);
    mc_a3 = 5'd14; mc_wd = 32'hE0;
    tick();
    chk("full_hold_count", count, 3'd4);
    chk("full_hold_ready", mc_ready, 1'b0);
    wb_we = 1'b0;
    tick();
    chk("full_pop10", rf_a3, 5'd10);
    chk("full_count3", count, 3'd3);
    chk("full_ready_back", mc_ready, 1'b1);
    tick();
    mc_valid = 1'b0;
    chk("full_pop11", rf_a3, 5'd11);
    chk("full_pushpop_count", count, 3'd3);
    tick();
    chk("full_pop12", rf_a3, 5'd12);
    tick();
    chk("full_pop13", rf_a3, 5'd13);
    tick();
    chk("full_pop14_a3", rf_a3, 5'd14);
    chk("full_pop14_wd", rf_wd, 32'hE0);
    chk("full_drained", count, 3'd0);

    // x0: a wb to x0 frees the port; an mc transfer to x0 is swallowed.
    mc_valid = 1'b1; mc_a3 = 5'd2; mc_wd = 32'h22;
    tick();
    mc_valid = 1'b0;
    chk("x0_queued", count, 3'd1);
    wb_we = 1'b1; wb_a3 = 5'd0; wb_wd = 32'h99;
    tick();
    chk("x0_pop_a3", rf_a3, 5'd2);
    chk("x0_pop_wd", rf_wd, 32'h22);
    chk("x0_count0", count, 3'd0);
    wb_we = 1'b0;
    mc_valid = 1'b1; mc_a3 = 5'd0; mc_wd = 32'h55;
    chk("x0_mc_ready", mc_ready, 1'b1);
    tick();
    mc_valid = 1'b0;
    chk("x0_mc_count", count, 3'd0);
    chk("x0_mc_pending", pending, 32'd0);
    tick();
    chk("x0_no_write", rf_we, 1'b0);

    // Starvation: stall_req rises after exactly 8 un-popped cycles.
    wb_we = 1'b1; wb_a3 = 5'd6; wb_wd = 32'h66;
    mc_valid = 1'b1; mc_a3 = 5'd8; mc_wd = 32'h88;
    tick();
    mc_valid = 1'b0;
    chk("starve_age0", stall_req, 1'b0);
    for (int k = 1; k <= 8; k++) begin
      tick();
      chk($sformatf("starve_age%0d", k), stall_req, (k == 8) ? 1'b1 : 1'b0);
    end
    tick();
    chk("starve_saturate", stall_req, 1'b1);
    wb_we = 1'b0;
    tick();
    chk("starve_pop_a3", rf_a3, 5'd8);
    chk("starve_pop_wd", rf_wd, 32'h88);
    chk("starve_clear", stall_req, 1'b0);

    // Reset mid-traffic discards the queue.
    wb_we = 1'b1; wb_a3 = 5'd1; wb_wd = 32'h01;
    for (int i = 0; i < 3; i++) begin
      mc_valid = 1'b1; mc_a3 = 5'(20 + i); mc_wd = 32'(i);
      tick();
    end
    chk("rmid_count3", count, 3'd3);
    reset = 1'b1; mc_a3 = 5'd23;
    tick();
    chk("rmid_count", count, 3'd0);
    chk("rmid_pending", pending, 32'd0);
    chk("rmid_rf_we", rf_we, 1'b0);
    chk("rmid_ready", mc_ready, 1'b1);
    reset = 1'b0; wb_we = 1'b0; mc_valid = 1'b0;
    tick();
    chk("rmid_after_we", rf_we, 1'b0);
    chk("rmid_after_count", count, 3'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
